mainfsm: RTL and testbench

Main control state machine for the multicycle ARM processor. It sequences every instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath mux selects and write enables once per cycle, and produces the unconditioned enables (NextPC, RegW, MemW, Branch) that conditional-execution logic qualifies with CondEx. It sits in the controller beside the ALU decoder and conditional-execution logic, and is fed from the instruction register.

---
 rtl/mainfsm.sv | 144 ++++++++++++++
 tb/tb_mainfsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mainfsm.sv
// Multicycle ARM main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// and decoding datapath selects and raw write enables from the state register.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       InstrDone,
  output logic [3:0] State
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4
  // DECODE   | read registers, PC+8 on ALU, pick path from Op
  // MEMADR   | compute base + offset for LDR/STR
  // MEMRD    | read data memory at ALUOut
  // MEMWB    | write loaded data to register file
  // MEMWR    | write data memory at ALUOut
  // EXECUTER | data-processing with register operand
  // EXECUTEI | data-processing with immediate operand
  // ALUWB    | write ALU result to register file
  // BRANCH   | compute branch target, request PC write
  // UNKNOWN  | undefined opcode, parked until reset
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = UNKNOWN;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = UNKNOWN;
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWR:    state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      default:  state_next = UNKNOWN;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    InstrDone = 1'b0;
    if (reset) begin
      // selects look like FETCH, but nothing may be written while in reset
      ALUSrcA   = 1'b1;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end else begin
      case (state)
        FETCH: begin
          IRWrite   = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          NextPC    = 1'b1;
        end
        DECODE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        MEMADR:   ALUSrcB = 2'b01;
        MEMRD:    AdrSrc  = 1'b1;
        MEMWB: begin
          ResultSrc = 2'b01;
          RegW      = 1'b1;
          InstrDone = 1'b1;
        end
        MEMWR: begin
          AdrSrc    = 1'b1;
          MemW      = 1'b1;
          InstrDone = 1'b1;
        end
        EXECUTER: ALUOp = 1'b1;
        EXECUTEI: begin
          ALUSrcB = 2'b01;
          ALUOp   = 1'b1;
        end
        ALUWB: begin
          RegW      = 1'b1;
          InstrDone = 1'b1;
        end
        BRANCH: begin
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          Branch    = 1'b1;
          InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_mainfsm.sv
// Testbench for mainfsm: directed vector table, multi-cycle corner sequences,
// and randomized instruction streams against an instruction-path reference model.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, InstrDone;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .InstrDone(InstrDone), .State(State)
  );

  always #5 clk = ~clk;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, InstrDone}
  logic [12:0] outs;
  assign outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, InstrDone};

  function automatic logic [12:0] spec_out(int st, logic rst);
    if (rst) return 13'b0_0_1_10_10_0_0_0_0_0_0;
    case (st)
      0:  return 13'b1_0_1_10_10_0_1_0_0_0_0;
      1:  return 13'b0_0_1_10_10_0_0_0_0_0_0;
      2:  return 13'b0_0_0_01_00_0_0_0_0_0_0;
      3:  return 13'b0_1_0_00_00_0_0_0_0_0_0;
      4:  return 13'b0_0_0_00_01_0_0_1_0_0_1;
      5:  return 13'b0_1_0_00_00_0_0_0_1_0_1;
      6:  return 13'b0_0_0_00_00_1_0_0_0_0_0;
      7:  return 13'b0_0_0_01_00_1_0_0_0_0_0;
      8:  return 13'b0_0_0_00_00_0_0_1_0_0_1;
      9:  return 13'b0_0_0_01_10_0_0_0_0_1_1;
      default: return 13'b0;
    endcase
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [5:0] funct;
    int         st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] o, input logic [5:0] f, input int s);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.st = s;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [1:0] o, input logic [5:0] f);
    @(posedge clk);
    #1;
    reset = r; Op = o; Funct = f;
  endtask

  // reference model state
  int exp_st;
  int pend[$];
  int retired_exp, retired_dut, unk_cycles;

  task automatic model_step(input logic r, input logic [1:0] o, input logic [5:0] f);
    if (r) begin
      exp_st = 0;
      pend.delete();
    end else if (exp_st == 10) begin
      exp_st = 10;
    end else if (exp_st == 0) begin
      exp_st = 1;
    end else if (exp_st == 1) begin
      case (o)
        2'b00:   pend = f[5] ? '{7, 8} : '{6, 8};
        2'b01:   pend = '{2};
        2'b10:   pend = '{9};
        default: pend = '{10};
      endcase
      exp_st = pend.pop_front();
    end else if (exp_st == 2) begin
      pend = f[0] ? '{3, 4} : '{5};
      exp_st = pend.pop_front();
    end else begin
      exp_st = (pend.size() > 0) ? pend.pop_front() : 0;
    end
  endtask

  initial begin
    int dcount, bcount, fcount, ucount;
    logic       r;
    logic [1:0] o;
    logic [5:0] f;

    reset = 1'b1; Op = 2'b00; Funct = 6'b0;

    // directed table: one entry per cycle, state expected during that cycle
    add(1, 2'b00, 6'b000000, 0);
    add(0, 2'b01, 6'b011001, 0);  add(0, 2'b01, 6'b011001, 1);  add(0, 2'b01, 6'b011001, 2);
    add(0, 2'b01, 6'b011001, 3);  add(0, 2'b01, 6'b011001, 4);
    add(0, 2'b01, 6'b011000, 0);  add(0, 2'b01, 6'b011000, 1);  add(0, 2'b01, 6'b011000, 2);
    add(0, 2'b01, 6'b011000, 5);
    add(0, 2'b00, 6'b001000, 0);  add(0, 2'b00, 6'b001000, 1);  add(0, 2'b00, 6'b001000, 6);
    add(0, 2'b00, 6'b001000, 8);
    add(0, 2'b00, 6'b101000, 0);  add(0, 2'b00, 6'b101000, 1);  add(0, 2'b00, 6'b101000, 7);
    add(0, 2'b00, 6'b101000, 8);
    add(0, 2'b10, 6'b000000, 0);  add(0, 2'b10, 6'b000000, 1);  add(0, 2'b10, 6'b000000, 9);
    add(0, 2'b11, 6'b000000, 0);  add(0, 2'b11, 6'b000000, 1);  add(0, 2'b00, 6'b000000, 10);
    add(0, 2'b01, 6'b000001, 10); add(1, 2'b00, 6'b000000, 10);
    add(0, 2'b01, 6'b011001, 0);  add(0, 2'b01, 6'b011001, 1);  add(1, 2'b01, 6'b011001, 2);
    add(0, 2'b10, 6'b000000, 0);  add(0, 2'b10, 6'b000000, 1);  add(0, 2'b00, 6'b000000, 9);
    // LDR with Op/Funct toggling outside the sampling states
    add(0, 2'b11, 6'b110110, 0);  add(0, 2'b01, 6'b000000, 1);  add(0, 2'b11, 6'b000001, 2);
    add(0, 2'b11, 6'b000000, 3);  add(0, 2'b10, 6'b100000, 4);
    add(0, 2'b00, 6'b000000, 0);

    @(posedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].funct);
      @(negedge clk);
      chk($sformatf("tbl%0d_state", i), int'(State), tbl[i].st);
      chk($sformatf("tbl%0d_outs", i), int'(outs), int'(spec_out(tbl[i].st, tbl[i].rst)));
    end

    // five back-to-back branches: 15 cycles, 5 retirements
    drive(1, 2'b10, 6'b0);
    dcount = 0; bcount = 0; fcount = 0;
    for (int c = 0; c < 15; c++) begin
      drive(0, 2'b10, 6'b0);
      @(negedge clk);
      dcount += int'(InstrDone);
      bcount += int'(Branch);
      fcount += int'(State == 4'd0);
    end
    chk("br5_done", dcount, 5);
    chk("br5_branch", bcount, 5);
    chk("br5_fetch", fcount, 5);
    drive(0, 2'b10, 6'b0);
    @(negedge clk);
    chk("br5_next_fetch", int'(State), 0);

    // undefined op parks for 20 cycles, then a single reset cycle recovers
    drive(1, 2'b11, 6'b0);
    drive(0, 2'b11, 6'b0);
    drive(0, 2'b11, 6'b0);
    ucount = 0;
    for (int c = 0; c < 20; c++) begin
      drive(0, 2'($urandom_range(0, 3)), 6'($urandom));
      @(negedge clk);
      if (State == 4'd10 && outs == 13'b0) ucount++;
    end
    chk("unk_20", ucount, 20);
    drive(1, 2'b00, 6'b0);
    drive(0, 2'b00, 6'b0);
    @(negedge clk);
    chk("unk_recover_state", int'(State), 0);
    chk("unk_recover_outs", int'(outs), int'(spec_out(0, 1'b0)));

    // randomized stream against the instruction-path model
    drive(1, 2'b00, 6'b0);
    exp_st = 0; pend.delete();
    retired_exp = 0; retired_dut = 0; unk_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 49) == 0) || (unk_cycles >= 6);
      o = 2'($urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2));
      f = 6'($urandom);
      drive(r, o, f);
      @(negedge clk);
      chk("rnd_state", int'(State), exp_st);
      chk("rnd_outs", int'(outs), int'(spec_out(exp_st, r)));
      if (!r && (exp_st == 4 || exp_st == 5 || exp_st == 8 || exp_st == 9)) retired_exp++;
      retired_dut += int'(InstrDone);
      unk_cycles = (exp_st == 10 && !r) ? unk_cycles + 1 : 0;
      model_step(r, o, f);
    end
    chk("rnd_retired", retired_dut, retired_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
